// File: rtl/flop_response_checker.sv
// Response checker for a clk/reset/d -> q flop under test: models the expected q from the
// observed stimulus, compares every CHECK cycle and keeps saturating pass/fail statistics.
module flop_response_checker #(
    parameter int LATENCY = 1,
    parameter int WARMUP  = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             d_obs,
    input  logic             dut_reset_obs,
    input  logic             q_obs,
    output logic             busy,
    output logic             err_pulse,
    output logic             fail,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, WARM, CHECK} state_t;

    state_t             state_q, state_d;
    logic [7:0]         warm_q, warm_d;
    logic [LATENCY-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
    logic [CNT_W-1:0]   fidx_q, fidx_d;
    logic               fail_q, fail_d;
    logic               err_q, err_d;
    logic               exp_q;

    assign exp_q = pipe_q[LATENCY-1];

    // Expected-q history runs in every state so it is already valid when CHECK starts.
    always_comb begin
        pipe_d = pipe_q;
        if (dut_reset_obs) pipe_d = '0;
        else               pipe_d = LATENCY'({pipe_q, d_obs});
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        case (state_q)
            IDLE: if (en) begin
                if (WARMUP == 0) state_d = CHECK;
                else begin
                    state_d = WARM;
                    warm_d  = 8'(WARMUP - 1);
                end
            end
            WARM: begin
                if (!en)                state_d = IDLE;
                else if (warm_q == 8'd0) state_d = CHECK;
                else                    warm_d  = warm_q - 8'd1;
            end
            CHECK: if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    always_comb begin
        scnt_d = scnt_q;
        mcnt_d = mcnt_q;
        fidx_d = fidx_q;
        fail_d = fail_q;
        err_d  = 1'b0;
        if (clr) begin
            scnt_d = '0;
            mcnt_d = '0;
            fidx_d = '0;
            fail_d = 1'b0;
        end else if (state_q == CHECK) begin
            if (scnt_q != '1) scnt_d = scnt_q + CNT_W'(1);
            if (q_obs != exp_q) begin
                err_d = 1'b1;
                if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
                // Index is the pre-increment sample count, i.e. this sample's 0-based position.
                if (!fail_q) begin
                    fidx_d = scnt_q;
                    fail_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            warm_q  <= '0;
            pipe_q  <= '0;
            scnt_q  <= '0;
            mcnt_q  <= '0;
            fidx_q  <= '0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            pipe_q  <= pipe_d;
            scnt_q  <= scnt_d;
            mcnt_q  <= mcnt_d;
            fidx_q  <= fidx_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign err_pulse     = err_q;
    assign fail          = fail_q;
    assign sample_cnt    = scnt_q;
    assign mismatch_cnt  = mcnt_q;
    assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_flop_response_checker.sv
// Three checker configurations share one stimulus stream; a cycle-history reference model
// predicts every output each cycle, plus directed checks for the listed scenarios.
module tb_flop_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, en = 1'b0, clr = 1'b0, d_obs = 1'b0, dut_reset_obs = 1'b0, q_obs = 1'b0;

    logic        a_busy, a_err, a_fail;
    logic [15:0] a_scnt, a_mcnt, a_fidx;
    logic        b_busy, b_err, b_fail;
    logic [3:0]  b_scnt, b_mcnt, b_fidx;
    logic        c_busy, c_err, c_fail;
    logic [7:0]  c_scnt, c_mcnt, c_fidx;

    flop_response_checker #(.LATENCY(1), .WARMUP(2), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d_obs(d_obs),
        .dut_reset_obs(dut_reset_obs), .q_obs(q_obs), .busy(a_busy), .err_pulse(a_err),
        .fail(a_fail), .sample_cnt(a_scnt), .mismatch_cnt(a_mcnt), .first_err_idx(a_fidx));
    flop_response_checker #(.LATENCY(1), .WARMUP(2), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d_obs(d_obs),
        .dut_reset_obs(dut_reset_obs), .q_obs(q_obs), .busy(b_busy), .err_pulse(b_err),
        .fail(b_fail), .sample_cnt(b_scnt), .mismatch_cnt(b_mcnt), .first_err_idx(b_fidx));
    flop_response_checker #(.LATENCY(3), .WARMUP(0), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d_obs(d_obs),
        .dut_reset_obs(dut_reset_obs), .q_obs(q_obs), .busy(c_busy), .err_pulse(c_err),
        .fail(c_fail), .sample_cnt(c_scnt), .mismatch_cnt(c_mcnt), .first_err_idx(c_fidx));

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance config and state, history of (d, pipeline-clearing reset).
    int   lat_of[3]  = '{1, 1, 3};
    int   wu_of[3]   = '{2, 2, 0};
    int   max_of[3]  = '{65535, 15, 255};
    int   m_run[3];
    logic m_busy[3], m_err[3], m_fail[3];
    int   m_scnt[3], m_mcnt[3], m_fidx[3];
    bit   hd[$];
    bit   hr[$];
    logic q_ff = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected q for latency L: d from L cycles ago, zero if any reset landed in between.
    function automatic bit exp_for(input int L);
        bit e;
        if (hd.size() < L) return 1'b0;
        e = hd[hd.size() - L];
        for (int k = 1; k <= L; k++) if (hr[hd.size() - k]) e = 1'b0;
        return e;
    endfunction

    task automatic model_update(input bit rst_, input bit en_, input bit clr_, input bit d_,
                                input bit drst_, input bit q_);
        for (int i = 0; i < 3; i++) begin
            bit e, checking;
            e = exp_for(lat_of[i]);
            checking = (m_run[i] >= wu_of[i] + 1);
            if (rst_ || clr_) begin
                m_scnt[i] = 0; m_mcnt[i] = 0; m_fidx[i] = 0;
                m_fail[i] = 1'b0; m_err[i] = 1'b0; m_run[i] = 0;
            end else begin
                m_err[i] = 1'b0;
                if (checking) begin
                    if (q_ != e) begin
                        m_err[i] = 1'b1;
                        if (!m_fail[i]) begin m_fidx[i] = m_scnt[i]; m_fail[i] = 1'b1; end
                        if (m_mcnt[i] < max_of[i]) m_mcnt[i]++;
                    end
                    if (m_scnt[i] < max_of[i]) m_scnt[i]++;
                end
                m_run[i] = en_ ? ((m_run[i] < 1000) ? m_run[i] + 1 : 1000) : 0;
            end
            m_busy[i] = (m_run[i] >= 1);
        end
        hd.push_back(d_);
        hr.push_back(rst_ | drst_);
        if (hd.size() > 8) begin void'(hd.pop_front()); void'(hr.pop_front()); end
    endtask

    task automatic compare_model();
        chk("A.busy", 32'(a_busy), 32'(m_busy[0]));  chk("A.err", 32'(a_err), 32'(m_err[0]));
        chk("A.fail", 32'(a_fail), 32'(m_fail[0]));  chk("A.scnt", 32'(a_scnt), m_scnt[0]);
        chk("A.mcnt", 32'(a_mcnt), m_mcnt[0]);       chk("A.fidx", 32'(a_fidx), m_fidx[0]);
        chk("B.busy", 32'(b_busy), 32'(m_busy[1]));  chk("B.err", 32'(b_err), 32'(m_err[1]));
        chk("B.fail", 32'(b_fail), 32'(m_fail[1]));  chk("B.scnt", 32'(b_scnt), m_scnt[1]);
        chk("B.mcnt", 32'(b_mcnt), m_mcnt[1]);       chk("B.fidx", 32'(b_fidx), m_fidx[1]);
        chk("C.busy", 32'(c_busy), 32'(m_busy[2]));  chk("C.err", 32'(c_err), 32'(m_err[2]));
        chk("C.fail", 32'(c_fail), 32'(m_fail[2]));  chk("C.scnt", 32'(c_scnt), m_scnt[2]);
        chk("C.mcnt", 32'(c_mcnt), m_mcnt[2]);       chk("C.fidx", 32'(c_fidx), m_fidx[2]);
    endtask

    // One cycle: drive inputs, q_obs = ideal flop output optionally inverted, then check.
    task automatic step(input bit rst_, input bit en_, input bit clr_, input bit d_,
                        input bit drst_, input bit inv_);
        bit q_;
        q_ = q_ff ^ inv_;
        reset = rst_; en = en_; clr = clr_; d_obs = d_; dut_reset_obs = drst_; q_obs = q_;
        @(posedge clk);
        q_ff = drst_ ? 1'b0 : d_;
        model_update(rst_, en_, clr_, d_, drst_, q_);
        #1;
        compare_model();
    endtask

    int ep;
    int m0;
    int i4;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_busy[i] = 0; m_err[i] = 0; m_fail[i] = 0;
            m_scnt[i] = 0; m_mcnt[i] = 0; m_fidx[i] = 0;
        end

        // Reset with random other inputs.
        for (int c = 0; c < 3; c++)
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst.busy", 32'(a_busy), 0);  chk("rst.scnt", 32'(a_scnt), 0);
        chk("rst.fail", 32'(a_fail), 0);  chk("rst.err", 32'(a_err), 0);

        // Ideal flop, toggling d, en high for 22 cycles.
        step(0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 22; c++) step(0, 1, 0, 1'(c), 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t2.scnt", 32'(a_scnt), 20);  chk("t2.mcnt", 32'(a_mcnt), 0);
        chk("t2.fail", 32'(a_fail), 0);   chk("t2.busy", 32'(a_busy), 0);

        // Same, q inverted on sample index 5 (checking starts on the fourth en cycle).
        step(0, 0, 1, 0, 0, 0);
        ep = 0;
        for (int c = 0; c < 23; c++) begin
            step(0, (c < 22), 0, 1'(c), 0, (c == 8));
            if (a_err === 1'b1) ep++;
            if (c > 9) chk("t3.fail_held", 32'(a_fail), 1);
        end
        chk("t3.pulses", ep, 1);          chk("t3.mcnt", 32'(a_mcnt), 1);
        chk("t3.fidx", 32'(a_fidx), 5);   chk("t3.scnt", 32'(a_scnt), 20);

        // DUT reset pulse mid-CHECK: first with q=0, then q forced high while exp=0.
        step(0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 6; c++) step(0, 1, 0, 1'($urandom), 0, 0);
        for (int r = 0; r < 2; r++) begin
            m0 = int'(a_mcnt);
            for (int c = 0; c < 6; c++)
                step(0, 1, 0, (c == 4), (c == 1 || c == 2), (r == 1) && (c == 2 || c == 3));
            i4 = int'(a_mcnt) - m0;
            chk(r == 0 ? "t4.q0" : "t4.q1", i4, r == 0 ? 0 : 2);
        end

        // Narrow counters saturate at 15 with q always wrong.
        step(0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 24; c++) step(0, 1, 0, 1'($urandom), 0, 1);
        chk("t5.mcnt", 32'(b_mcnt), 15);  chk("t5.scnt", 32'(b_scnt), 15);
        chk("t5.fail", 32'(b_fail), 1);   chk("t5.fidx", 32'(b_fidx), 0);
        step(0, 0, 0, 0, 0, 0);

        // en drop mid-CHECK holds stats; clr with en in the same cycle wins.
        step(0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 8; c++) step(0, 1, 0, 1'($urandom), 0, (c == 5));
        step(0, 0, 0, 0, 0, 0);
        chk("t6.idle", 32'(a_busy), 0);
        step(0, 0, 0, 1, 0, 1);
        chk("t6.held_s", 32'(a_scnt), 6); chk("t6.held_m", 32'(a_mcnt), 1);
        for (int c = 0; c < 5; c++) step(0, 1, 0, 1'($urandom), 0, 0);
        step(0, 1, 1, 0, 0, 1);
        chk("t6.clr_busy", 32'(a_busy), 0); chk("t6.clr_scnt", 32'(a_scnt), 0);
        chk("t6.clr_fail", 32'(a_fail), 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t6.rewarm", 32'(a_busy), 1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r < 2, $urandom_range(0, 9) != 0, r >= 2 && r < 5, 1'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
